// File: rtl/seq_match_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_match_monitor_if
// Brief    : Detection/status bundle between the sequence detector side and
//            seq_match_monitor. min_gap exists only with SEQ_MON_GAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_match_monitor_if #(
    parameter int CNT_W = 8
);
    logic             match;
    logic             clr;
    logic [CNT_W-1:0] total_cnt;
    logic [CNT_W-1:0] win_cnt;
    logic             burst;
    logic [1:0]       state;
`ifdef SEQ_MON_GAP_EN
    logic [CNT_W-1:0] min_gap;

    modport master (output match, clr, input total_cnt, win_cnt, burst, state, min_gap);
    modport slave  (input match, clr, output total_cnt, win_cnt, burst, state, min_gap);
`else
    modport master (output match, clr, input total_cnt, win_cnt, burst, state);
    modport slave  (input match, clr, output total_cnt, win_cnt, burst, state);
`endif
endinterface
`default_nettype wire

// File: rtl/seq_match_monitor.sv
`default_nettype none
// ============================================================================
// Module   : seq_match_monitor
// Brief    : Counts detector pulses, tracks a fixed observation window and
//            raises a sticky burst alarm. SEQ_MON_GAP_EN adds min_gap tracking.
// Revision : 1.0 - initial release
// ============================================================================
module seq_match_monitor #(
    parameter int CNT_W    = 8,
    parameter int WIN_LEN  = 16,
    parameter int BURST_TH = 3
) (
    input  logic               clk,
    input  logic               rst,
    seq_match_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WINDOW = 2'd1,
        S_ALARM  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_MAX      = '1;
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_WIN_LAST = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] C_BURST_TH = CNT_W'(BURST_TH);

    state_t           r_state;
    logic [CNT_W-1:0] r_total_cnt;
    logic [CNT_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_timer;
    logic             r_burst;

    logic             w_accept;
    logic [CNT_W-1:0] w_win_inc;

    // clr shadows match in the same cycle
    assign w_accept  = bus.match & ~bus.clr;
    assign w_win_inc = (r_win_cnt == C_MAX) ? r_win_cnt : r_win_cnt + C_ONE;

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_total_cnt <= '0;
        end else if (w_accept && (r_total_cnt != C_MAX)) begin
            r_total_cnt <= r_total_cnt + C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_state   <= S_IDLE;
            r_win_cnt <= '0;
            r_timer   <= '0;
            r_burst   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_win_cnt <= C_ONE;
                        r_timer   <= C_WIN_LAST;
                        if (BURST_TH == 1) begin
                            r_state <= S_ALARM;
                            r_burst <= 1'b1;
                        end else if (WIN_LEN != 1) begin
                            r_state <= S_WINDOW;
                        end
                    end
                end
                S_WINDOW: begin
                    r_timer <= r_timer - C_ONE;
                    if (w_accept) begin
                        r_win_cnt <= w_win_inc;
                    end
                    // Threshold wins over expiry when both land on the last cycle
                    if (w_accept && (w_win_inc >= C_BURST_TH)) begin
                        r_state <= S_ALARM;
                        r_burst <= 1'b1;
                    end else if (r_timer == C_ONE) begin
                        r_state <= S_IDLE;
                    end
                end
                S_ALARM: begin
                    r_burst <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.total_cnt = r_total_cnt;
    assign bus.win_cnt   = r_win_cnt;
    assign bus.burst     = r_burst;
    assign bus.state     = r_state;

`ifdef SEQ_MON_GAP_EN
    logic [CNT_W-1:0] r_gap;
    logic [CNT_W-1:0] r_min_gap;
    logic             r_seen;

    // r_gap equals the distance to the previous accepted match on the match cycle
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_gap     <= '0;
            r_min_gap <= '1;
            r_seen    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gap  <= C_ONE;
                r_seen <= 1'b1;
                if (r_seen && (r_gap < r_min_gap)) begin
                    r_min_gap <= r_gap;
                end
            end else if (r_gap != C_MAX) begin
                r_gap <= r_gap + C_ONE;
            end
        end
    end

    assign bus.min_gap = r_min_gap;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_match_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_match_monitor
// Brief    : Directed self-checking bench for seq_match_monitor (default
//            parameters plus a WIN_LEN=1/BURST_TH=255 saturation instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_match_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    seq_match_monitor_if #(.CNT_W(8)) a ();
    seq_match_monitor_if #(.CNT_W(8)) b ();

    seq_match_monitor #(.CNT_W(8), .WIN_LEN(16), .BURST_TH(3)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (a.slave)
    );

    seq_match_monitor #(.CNT_W(8), .WIN_LEN(1), .BURST_TH(255)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock on DUT u0 with the given inputs; returns 1 ns after the edge
    task automatic cyc(input logic m, input logic c);
        a.match = m;
        a.clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    initial begin
        a.match = 1'b1;
        a.clr   = 1'b0;
        b.match = 1'b1;
        b.clr   = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_total", a.total_cnt, 0);
        chk("rst_win",   a.win_cnt,   0);
        chk("rst_burst", a.burst,     0);
        chk("rst_state", a.state,     0);
        chk("rst_total_u1", b.total_cnt, 0);
        b.match = 1'b0;
        rst     = 1'b0;

        // Burst: matches at 0, 5, 10
        cyc(1'b1, 1'b0);
        chk("b0_total", a.total_cnt, 1);
        chk("b0_win",   a.win_cnt,   1);
        chk("b0_state", a.state,     1);
        idle(4);
        cyc(1'b1, 1'b0);
        chk("b5_win",   a.win_cnt, 2);
        chk("b5_burst", a.burst,   0);
        idle(4);
        cyc(1'b1, 1'b0);
        chk("b10_win",   a.win_cnt, 3);
        chk("b10_burst", a.burst,   1);
        chk("b10_state", a.state,   2);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("alarm_total", a.total_cnt, 5);
        chk("alarm_win",   a.win_cnt,   3);
        chk("alarm_state", a.state,     2);
        cyc(1'b0, 1'b1);
        chk("clr_total", a.total_cnt, 0);
        chk("clr_win",   a.win_cnt,   0);
        chk("clr_burst", a.burst,     0);
        chk("clr_state", a.state,     0);

        // Expiry: matches at 0, 5, 16
        cyc(1'b1, 1'b0);
        idle(4);
        cyc(1'b1, 1'b0);
        idle(9);
        chk("exp14_state", a.state, 1);
        idle(1);
        chk("exp15_state", a.state,   0);
        chk("exp15_win",   a.win_cnt, 2);
        cyc(1'b1, 1'b0);
        chk("exp16_win",   a.win_cnt,   1);
        chk("exp16_state", a.state,     1);
        chk("exp16_burst", a.burst,     0);
        chk("exp16_total", a.total_cnt, 3);
        cyc(1'b0, 1'b1);

        // Last window cycle: matches at 0, 5, 15
        cyc(1'b1, 1'b0);
        idle(4);
        cyc(1'b1, 1'b0);
        idle(9);
        cyc(1'b1, 1'b0);
        chk("last15_win",   a.win_cnt, 3);
        chk("last15_burst", a.burst,   1);
        chk("last15_state", a.state,   2);
        cyc(1'b0, 1'b1);

        // clr with match in the same cycle drops the match
        cyc(1'b1, 1'b0);
        chk("cm_pre_total", a.total_cnt, 1);
        cyc(1'b1, 1'b1);
        chk("cm_total", a.total_cnt, 0);
        chk("cm_win",   a.win_cnt,   0);
        chk("cm_state", a.state,     0);

        // rst during WINDOW
        cyc(1'b1, 1'b0);
        chk("rw_pre_state", a.state, 1);
        rst = 1'b1;
        cyc(1'b1, 1'b0);
        rst = 1'b0;
        chk("rw_state", a.state,     0);
        chk("rw_total", a.total_cnt, 0);
        chk("rw_win",   a.win_cnt,   0);
        a.match = 1'b0;

`ifdef SEQ_MON_GAP_EN
        // Gap: matches at 0, 7, 10, 20
        chk("gap_init", a.min_gap, 255);
        cyc(1'b1, 1'b0);
        chk("gap_m0", a.min_gap, 255);
        idle(6);
        cyc(1'b1, 1'b0);
        chk("gap_m7", a.min_gap, 7);
        idle(2);
        cyc(1'b1, 1'b0);
        chk("gap_m10", a.min_gap, 3);
        idle(9);
        cyc(1'b1, 1'b0);
        chk("gap_m20", a.min_gap, 3);
        cyc(1'b0, 1'b1);
        chk("gap_clr", a.min_gap, 255);
`endif

        // Saturation on u1: 300 consecutive matches
        b.match = 1'b1;
        @(posedge clk); #1;
        chk("sat1_total", b.total_cnt, 1);
        chk("sat1_win",   b.win_cnt,   1);
        chk("sat1_state", b.state,     0);
        for (int i = 0; i < 253; i++) begin
            @(posedge clk); #1;
        end
        chk("sat254_total", b.total_cnt, 254);
        @(posedge clk); #1;
        chk("sat255_total", b.total_cnt, 255);
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
        end
        chk("sat300_total", b.total_cnt, 255);
        chk("sat300_win",   b.win_cnt,   1);
        chk("sat300_state", b.state,     0);
        chk("sat300_burst", b.burst,     0);
        b.match = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_match_monitor.md
# seq_match_monitor

Downstream consumer of the serial sequence detector's one-cycle `out` pulse. Counts detections, opens a fixed-length observation window on the first detection, and raises a sticky `burst` alarm when `BURST_TH` detections fall inside one window. It sits between the detector and the control and status logic, which reads the counts and clears the alarm.

## Interface
- `CNT_W`, default 8: width of all counters (`total_cnt`, `win_cnt`, `min_gap`).
- `WIN_LEN`, default 16: window length in cycles, counted from and including the opening detection. Legal range: 1 to 2^CNT_W−1.
- `BURST_TH`, default 3: detections per window that trigger the alarm. Legal range: 1 to 2^CNT_W−1.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `match`, in, 1: detection pulse, driven directly by the detector's registered `out`.
- `clr`, in, 1: synchronous clear of counters, alarm and FSM. Priority is below `rst` and above `match`.
- `total_cnt`, out, CNT_W: saturating count of accepted matches.
- `win_cnt`, out, CNT_W: matches counted in the current or last window.
- `burst`, out, 1: sticky alarm. Registered.
- `state`, out, 2: FSM state, encoded IDLE=0, WINDOW=1, ALARM=2.
- `min_gap`, out, CNT_W: present only with `SEQ_MON_GAP_EN`.

## Operation
- Reset or `clr`:
  - `total_cnt`=0, `win_cnt`=0, `burst`=0, `state`=IDLE, internal timer=0.
  - With `SEQ_MON_GAP_EN`: `min_gap`=all ones, gap counter=0, first-seen flag=0.
  - A `match` in the `clr` cycle is dropped.
- Accepted match: a `match`=1 in any cycle that is not a `rst` or `clr` cycle.
- `total_cnt` increments on each accepted match and saturates at 2^CNT_W−1. It keeps counting in every state, including ALARM.
- IDLE, on accepted match:
  - `win_cnt`←1 and timer←WIN_LEN−1.
  - If BURST_TH==1, go to ALARM and set `burst`←1.
  - Else if WIN_LEN==1, stay in IDLE; the window closes immediately.
  - Else go to WINDOW.
- IDLE, no match: hold. `win_cnt` keeps its last value.
- WINDOW, every cycle:
  - Timer decrements.
  - An accepted match increments `win_cnt` (saturating).
  - If the incremented `win_cnt` ≥ BURST_TH, go to ALARM and set `burst`←1. This takes priority over expiry in the same cycle.
  - Else if timer==1 in this cycle (the last window cycle), go to IDLE. A match in this cycle counts toward the closing window, not a new one.
- ALARM: `burst` stays 1 and `win_cnt` freezes. Only `clr` or `rst` exits, to IDLE.
- State encoding 3 is unreachable. If entered, it recovers to IDLE on the next cycle with no output change.

## Timing
- All outputs are registered. A match sampled at edge t is visible on `total_cnt` and `win_cnt` after edge t.
- `burst` rises after the edge that samples the threshold-reaching match, which is one cycle of latency.
- A window opened by a match at cycle t accepts matches at cycles t through t+WIN_LEN−1. The FSM is back in IDLE at cycle t+WIN_LEN.
- A match at t+WIN_LEN is sampled in IDLE and opens a new window with `win_cnt`=1.
- `rst` asserted mid-window or in ALARM takes effect at the next edge, with no residual state.

## Configuration
- `SEQ_MON_GAP_EN` defined:
  - Adds the `min_gap` port and a saturating gap counter. The counter increments each cycle and resets to 1 on the cycle after an accepted match.
  - On each accepted match after the first, `min_gap`←min(`min_gap`, gap), where gap is the cycle distance to the previous accepted match.
  - The first match after reset or `clr` only arms the measurement.
- `SEQ_MON_GAP_EN` undefined: the port, counter and comparator are absent. All other behaviour is identical.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `match`=1 → `total_cnt`=0, `win_cnt`=0, `burst`=0, `state`=0.
- Burst: matches at cycles 0, 5, 10 (defaults) → `win_cnt`=3, `burst`=1 and `state`=2 from cycle 11; further matches raise `total_cnt` only; `clr` → IDLE with all zero.
- Window expiry: matches at 0, 5, then 16 → `state`=0 at cycle 16; the match at 16 opens a new window with `win_cnt`=1 and `burst`=0. A match at 15 instead gives `win_cnt`=3 and `burst`=1.
- Saturation: 300 consecutive matches with WIN_LEN=1 and BURST_TH=255 → `total_cnt` stops at 255 and `win_cnt` follows the window rules.
- `clr` with `match` in the same cycle → the match is dropped and `total_cnt`=0 the next cycle. `rst` during WINDOW → IDLE next cycle.
- Gap (`SEQ_MON_GAP_EN`): matches at 0, 7, 10, 20 → `min_gap` reads 255, 255, 7, 3, 3 after each match; after `clr` it reads 255.
